// File: rtl/ipsxe_floating_point_op_arb_v1_0.sv
// Round-robin arbiter sharing one fixed-latency FP core between N_REQ AXI4-Stream requesters.
// Optional build macro IPSXE_FLT_ARB_PRIO0_EN: requester 0 gets strict priority over the rest.
module ipsxe_floating_point_op_arb_v1_0 #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CORE_LATENCY = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned ID_W         = 3
) (
    input  logic                        i_aclk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_s_tvalid,
    output logic [N_REQ-1:0]            o_s_tready,
    input  logic [N_REQ*DATA_W-1:0]     i_s_a_tdata,
    input  logic [N_REQ*DATA_W-1:0]     i_s_b_tdata,
    input  logic [N_REQ*8-1:0]          i_s_op_tdata,
    output logic                        o_core_tvalid,
    output logic [DATA_W-1:0]           o_core_a_tdata,
    output logic [DATA_W-1:0]           o_core_b_tdata,
    output logic [7:0]                  o_core_op_tdata,
    input  logic                        i_core_rvalid,
    input  logic [DATA_W-1:0]           i_core_rdata,
    output logic                        o_m_tvalid,
    input  logic                        i_m_tready,
    output logic [DATA_W-1:0]           o_m_tdata,
    output logic [ID_W-1:0]             o_m_tuser,
    output logic                        o_seq_err,
    output logic [$clog2(FIFO_DEPTH):0] o_outstanding
);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned PW   = $clog2(N_REQ);
    localparam int unsigned EW   = ID_W + DATA_W;
    localparam int unsigned LAST = CORE_LATENCY;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt_idx;
    logic [PW-1:0]     ptr_next;
    logic              found;
    logic              can_issue;
    logic              accept;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [7:0]        sel_op;

    // Credits: every accepted op already owns a FIFO slot, so the core can never overflow it
    assign can_issue = (o_outstanding < CW'(FIFO_DEPTH));
    assign accept    = found & can_issue & ~i_rst;
    assign o_s_tready = accept ? (N_REQ'(1) << gnt_idx) : '0;
    assign ptr_next  = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);

    // First valid requester at or after the round-robin pointer, with wrap
    always_comb begin
        int unsigned idx;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
`ifdef IPSXE_FLT_ARB_PRIO0_EN
        if (i_s_tvalid[0]) found = 1'b1;
`endif
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && i_s_tvalid[PW'(idx)]) begin
                found   = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_a  = i_s_a_tdata[i*DATA_W +: DATA_W];
                sel_b  = i_s_b_tdata[i*DATA_W +: DATA_W];
                sel_op = i_s_op_tdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr          <= '0;
            o_core_tvalid   <= 1'b0;
            o_core_a_tdata  <= '0;
            o_core_b_tdata  <= '0;
            o_core_op_tdata <= '0;
        end else begin
            o_core_tvalid <= accept;
            if (accept) begin
                o_core_a_tdata  <= sel_a;
                o_core_b_tdata  <= sel_b;
                o_core_op_tdata <= sel_op;
`ifdef IPSXE_FLT_ARB_PRIO0_EN
                if (gnt_idx != '0) rr_ptr <= ptr_next;
`else
                rr_ptr <= ptr_next;
`endif
            end
        end
    end

    // Tag pipeline: stage LAST lines up with the core result of the same issue
    logic [LAST:0]   tag_v;
    logic [ID_W-1:0] tag_id [LAST+1];

    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            tag_v <= '0;
            for (int unsigned k = 0; k <= LAST; k++) tag_id[k] <= '0;
        end else begin
            tag_v     <= {tag_v[LAST-1:0], accept};
            tag_id[0] <= ID_W'(gnt_idx);
            for (int unsigned k = 1; k <= LAST; k++) tag_id[k] <= tag_id[k-1];
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_next;
    logic [AW:0]   rd_next;
    logic [EW-1:0] head_next;

    assign push    = i_core_rvalid & tag_v[LAST];
    assign pop     = o_m_tvalid & i_m_tready;
    assign wr_next = wr_ptr + {{AW{1'b0}}, push};
    assign rd_next = rd_ptr + {{AW{1'b0}}, pop};
    // Bypass the array when the entry being written becomes the new head
    assign head_next = (push && (rd_next == wr_ptr)) ? {tag_id[LAST], i_core_rdata}
                                                     : mem[rd_next[AW-1:0]];

    always_ff @(posedge i_aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {tag_id[LAST], i_core_rdata};
    end

    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_m_tvalid    <= 1'b0;
            o_m_tdata     <= '0;
            o_m_tuser     <= '0;
            o_seq_err     <= 1'b0;
            o_outstanding <= '0;
        end else begin
            wr_ptr     <= wr_next;
            rd_ptr     <= rd_next;
            o_m_tvalid <= (wr_next != rd_next);
            if (wr_next != rd_next) {o_m_tuser, o_m_tdata} <= head_next;
            if (i_core_rvalid ^ tag_v[LAST]) o_seq_err <= 1'b1;
            case ({accept, pop})
                2'b10:   o_outstanding <= o_outstanding + CW'(1);
                2'b01:   o_outstanding <= o_outstanding - CW'(1);
                default: o_outstanding <= o_outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_ipsxe_floating_point_op_arb_v1_0.sv
// Bench for ipsxe_floating_point_op_arb_v1_0: core stub plus queue-based reference model.
module tb_ipsxe_floating_point_op_arb_v1_0;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int L  = 4;
    localparam int FD = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   s_tvalid = '0;
    logic [3:0]   s_tready;
    logic [127:0] s_a = '0;
    logic [127:0] s_b = '0;
    logic [31:0]  s_op = '0;
    logic         core_tvalid;
    logic [31:0]  core_a;
    logic [31:0]  core_b;
    logic [7:0]   core_op;
    logic         core_rvalid;
    logic [31:0]  core_rdata;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [31:0]  m_tdata;
    logic [2:0]   m_tuser;
    logic         seq_err;
    logic [3:0]   outstanding;
    logic         stray_v = 1'b0;
    logic [31:0]  stray_d = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ipsxe_floating_point_op_arb_v1_0 dut (
        .i_aclk(clk), .i_rst(rst),
        .i_s_tvalid(s_tvalid), .o_s_tready(s_tready),
        .i_s_a_tdata(s_a), .i_s_b_tdata(s_b), .i_s_op_tdata(s_op),
        .o_core_tvalid(core_tvalid), .o_core_a_tdata(core_a),
        .o_core_b_tdata(core_b), .o_core_op_tdata(core_op),
        .i_core_rvalid(core_rvalid), .i_core_rdata(core_rdata),
        .o_m_tvalid(m_tvalid), .i_m_tready(m_tready),
        .o_m_tdata(m_tdata), .o_m_tuser(m_tuser),
        .o_seq_err(seq_err), .o_outstanding(outstanding)
    );

    // Core behaviour: one known FP vector, otherwise an arbitrary deterministic mix
    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] op);
        if (op == 8'h00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return (a ^ {b[15:0], b[31:16]}) + {24'h0, op};
    endfunction

    // Fixed-latency core stub
    logic [L-1:0] cpv;
    logic [31:0]  cpd [L];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cpv <= '0;
            for (int k = 0; k < L; k++) cpd[k] <= '0;
        end else begin
            cpv    <= {cpv[L-2:0], core_tvalid};
            cpd[0] <= core_fn(core_a, core_b, core_op);
            for (int k = 1; k < L; k++) cpd[k] <= cpd[k-1];
        end
    end
    assign core_rvalid = cpv[L-1] | stray_v;
    assign core_rdata  = stray_v ? stray_d : cpd[L-1];

    // Reference model
    typedef struct { int due; int id; logic [31:0] d; } infl_t;
    typedef struct { int id; logic [31:0] d; } res_t;
    infl_t       inflight[$];
    res_t        mfifo[$];
    int          m_ptr;
    int          m_out;
    int          cyc;
    bit          m_err;
    bit          m_iss_v;
    logic [31:0] m_la;
    logic [31:0] m_lb;
    logic [7:0]  m_lop;

    function automatic int exp_grant();
        if (m_out >= FD) return -1;
`ifdef IPSXE_FLT_ARB_PRIO0_EN
        if (s_tvalid[0]) return 0;
`endif
        for (int k = 0; k < N; k++)
            if (s_tvalid[2'((m_ptr + k) % N)]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = exp_grant();
        return (g < 0) ? 4'b0000 : 4'(1 << g);
    endfunction

    task automatic model_reset();
        inflight.delete();
        mfifo.delete();
        m_ptr = 0; m_out = 0; m_err = 0; m_iss_v = 0;
        m_la = '0; m_lb = '0; m_lop = '0;
    endtask

    task automatic model_step();
        int    g;
        bit    pop;
        res_t  r;
        infl_t f;
        g   = exp_grant();
        pop = (mfifo.size() > 0) && m_tready;
        if (pop) r = mfifo.pop_front();
        if (stray_v) m_err = 1;
        if (inflight.size() > 0 && inflight[0].due == cyc) begin
            f = inflight.pop_front();
            r.id = f.id; r.d = f.d;
            mfifo.push_back(r);
        end
        m_iss_v = (g >= 0);
        if (g >= 0) begin
            m_la  = 32'(s_a >> (g * 32));
            m_lb  = 32'(s_b >> (g * 32));
            m_lop = 8'(s_op >> (g * 8));
            f.due = cyc + 1 + L; f.id = g; f.d = core_fn(m_la, m_lb, m_lop);
            inflight.push_back(f);
`ifdef IPSXE_FLT_ARB_PRIO0_EN
            if (g != 0) m_ptr = (g + 1) % N;
`else
            m_ptr = (g + 1) % N;
`endif
        end
        m_out = m_out + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
        cyc++;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < N; i++) begin
            s_a[i*32 +: 32] = $urandom;
            s_b[i*32 +: 32] = $urandom;
            s_op[i*8 +: 8]  = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic drain_and_check(input string name);
        int guard;
        guard = 0;
        s_tvalid = '0;
        m_tready = 1'b1;
        while ((mfifo.size() > 0 || inflight.size() > 0) && guard < 100) begin
            @(negedge clk);
            checks++;
            if (m_tvalid !== (mfifo.size() > 0)) begin
                $display("FAIL %s drain_valid got %0b want %0b", name, m_tvalid, mfifo.size() > 0);
                errors++;
            end else if (m_tvalid && ({m_tuser, m_tdata} !== {3'(mfifo[0].id), mfifo[0].d})) begin
                $display("FAIL %s drain_data got %0d/%h want %0d/%h", name, m_tuser, m_tdata,
                         mfifo[0].id, mfifo[0].d);
                errors++;
            end
            advance();
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            $display("FAIL %s drain_timeout got %0d cycles want <100", name, guard);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (outstanding !== 4'd0 || m_tvalid !== 1'b0) begin
            $display("FAIL %s drain_idle got out=%0d valid=%0b want 0/0", name, outstanding, m_tvalid);
            errors++;
        end
        advance();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (core_tvalid !== 1'b0) begin $display("FAIL rst_core_tvalid got %0b want 0", core_tvalid); errors++; end
        checks++; if (core_a !== 32'd0) begin $display("FAIL rst_core_a got %h want 0", core_a); errors++; end
        checks++; if (core_b !== 32'd0) begin $display("FAIL rst_core_b got %h want 0", core_b); errors++; end
        checks++; if (core_op !== 8'd0) begin $display("FAIL rst_core_op got %h want 0", core_op); errors++; end
        checks++; if (m_tvalid !== 1'b0) begin $display("FAIL rst_m_tvalid got %0b want 0", m_tvalid); errors++; end
        checks++; if (m_tdata !== 32'd0) begin $display("FAIL rst_m_tdata got %h want 0", m_tdata); errors++; end
        checks++; if (m_tuser !== 3'd0) begin $display("FAIL rst_m_tuser got %0d want 0", m_tuser); errors++; end
        checks++; if (seq_err !== 1'b0) begin $display("FAIL rst_seq_err got %0b want 0", seq_err); errors++; end
        checks++; if (outstanding !== 4'd0) begin $display("FAIL rst_outstanding got %0d want 0", outstanding); errors++; end
        checks++; if (s_tready !== 4'd0) begin $display("FAIL rst_tready got %b want 0000", s_tready); errors++; end
        advance();
    endtask

    task automatic test_round_robin();
        int order [6];
        int n;
`ifdef IPSXE_FLT_ARB_PRIO0_EN
        order = '{0, 0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0, 1};
`endif
        s_tvalid = 4'hF;
        m_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_lanes();
            @(negedge clk);
            checks++;
            if (s_tready !== exp_ready() || s_tready !== 4'(1 << order[k])) begin
                $display("FAIL rr_grant[%0d] got %b want %b", k, s_tready, 4'(1 << order[k]));
                errors++;
            end
            advance();
        end
        s_tvalid = '0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_tvalid && n < 6) begin
                checks++;
                if (m_tuser !== 3'(order[n]) || m_tdata !== mfifo[0].d) begin
                    $display("FAIL rr_tuser[%0d] got %0d/%h want %0d/%h", n, m_tuser, m_tdata,
                             order[n], mfifo[0].d);
                    errors++;
                end
                n++;
            end
            advance();
        end
        checks++;
        if (n != 6) begin $display("FAIL rr_result_count got %0d want 6", n); errors++; end
        drain_and_check("rr");
    endtask

    task automatic test_single();
        s_a[32 +: 32] = 32'h3F800000;
        s_b[32 +: 32] = 32'h40000000;
        s_op[8 +: 8]  = 8'h00;
        s_tvalid = 4'b0010;
        m_tready = 1'b1;
        @(negedge clk);
        checks++; if (s_tready !== 4'b0010) begin $display("FAIL single_tready got %b want 0010", s_tready); errors++; end
        advance();
        s_tvalid = '0;
        @(negedge clk);
        checks++;
        if (core_tvalid !== 1'b1 || core_a !== 32'h3F800000 || core_b !== 32'h40000000 || core_op !== 8'h00) begin
            $display("FAIL single_issue got v=%0b a=%h b=%h op=%h want 1/3f800000/40000000/00",
                     core_tvalid, core_a, core_b, core_op);
            errors++;
        end
        advance();
        for (int r = 2; r <= 5; r++) begin
            @(negedge clk);
            checks++;
            if (m_tvalid !== 1'b0) begin $display("FAIL single_early_valid[%0d] got 1 want 0", r); errors++; end
            advance();
        end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h40400000 || m_tuser !== 3'd1) begin
            $display("FAIL single_result got v=%0b d=%h u=%0d want 1/40400000/1", m_tvalid, m_tdata, m_tuser);
            errors++;
        end
        advance();
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin $display("FAIL single_after_pop got 1 want 0"); errors++; end
        advance();
    endtask

    task automatic test_credit_stall();
        int acc;
        acc = 0;
        s_tvalid = 4'hF;
        m_tready = 1'b0;
        for (int c = 0; c < 14; c++) begin
            rand_lanes();
            @(negedge clk);
            checks++;
            if (s_tready !== exp_ready()) begin
                $display("FAIL stall_tready[%0d] got %b want %b", c, s_tready, exp_ready()); errors++;
            end
            if (|(s_tready & s_tvalid)) acc++;
            advance();
        end
        m_tready = 1'b1;
        @(negedge clk);
        checks++; if (acc != 8) begin $display("FAIL stall_accepts got %0d want 8", acc); errors++; end
        checks++; if (outstanding !== 4'd8) begin $display("FAIL stall_outstanding got %0d want 8", outstanding); errors++; end
        checks++; if (s_tready !== 4'd0) begin $display("FAIL stall_blocked got %b want 0000", s_tready); errors++; end
        checks++; if (m_tvalid !== 1'b1) begin $display("FAIL stall_head_valid got %0b want 1", m_tvalid); errors++; end
        advance();
        m_tready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (|(s_tready & s_tvalid)) acc++;
            advance();
        end
        @(negedge clk);
        checks++; if (acc != 1) begin $display("FAIL stall_refill got %0d want 1", acc); errors++; end
        checks++; if (outstanding !== 4'd8) begin $display("FAIL stall_refill_out got %0d want 8", outstanding); errors++; end
        advance();
        drain_and_check("stall");
    endtask

    task automatic test_accept_and_pop();
        m_tready = 1'b0;
        s_tvalid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            rand_lanes();
            advance();
        end
        s_tvalid = '0;
        for (int c = 0; c < 8; c++) advance();
        rand_lanes();
        s_tvalid = 4'b0100;
        m_tready = 1'b1;
        @(negedge clk);
        checks++;
        if (outstanding !== 4'd5 || m_tvalid !== 1'b1 || s_tready !== 4'b0100) begin
            $display("FAIL ap_setup got out=%0d v=%0b rdy=%b want 5/1/0100", outstanding, m_tvalid, s_tready);
            errors++;
        end
        advance();
        s_tvalid = '0;
        m_tready = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== 4'd5) begin $display("FAIL ap_outstanding got %0d want 5", outstanding); errors++; end
        advance();
        drain_and_check("accept_pop");
    endtask

    task automatic test_back_to_back_random();
        for (int c = 0; c < 300; c++) begin
            s_tvalid = 4'($urandom);
            rand_lanes();
            m_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++;
            if (s_tready !== exp_ready()) begin
                $display("FAIL rnd_tready[%0d] got %b want %b", c, s_tready, exp_ready()); errors++;
            end
            checks++;
            if (core_tvalid !== m_iss_v || core_a !== m_la || core_b !== m_lb || core_op !== m_lop) begin
                $display("FAIL rnd_issue[%0d] got %0b/%h/%h/%h want %0b/%h/%h/%h", c, core_tvalid, core_a,
                         core_b, core_op, m_iss_v, m_la, m_lb, m_lop);
                errors++;
            end
            checks++;
            if (m_tvalid !== (mfifo.size() > 0)) begin
                $display("FAIL rnd_m_tvalid[%0d] got %0b want %0b", c, m_tvalid, mfifo.size() > 0); errors++;
            end else if (m_tvalid && ({m_tuser, m_tdata} !== {3'(mfifo[0].id), mfifo[0].d})) begin
                $display("FAIL rnd_m_data[%0d] got %0d/%h want %0d/%h", c, m_tuser, m_tdata,
                         mfifo[0].id, mfifo[0].d);
                errors++;
            end
            checks++;
            if (outstanding !== 4'(m_out) || seq_err !== m_err) begin
                $display("FAIL rnd_count[%0d] got %0d/%0b want %0d/%0b", c, outstanding, seq_err, m_out, m_err);
                errors++;
            end
            advance();
        end
        drain_and_check("random");
    endtask

    task automatic test_reset_midflight();
        s_tvalid = 4'hF;
        m_tready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_lanes();
            advance();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (core_tvalid !== 1'b0 || m_tvalid !== 1'b0 || outstanding !== 4'd0 || s_tready !== 4'd0 ||
            core_a !== 32'd0 || m_tdata !== 32'd0 || seq_err !== 1'b0) begin
            $display("FAIL midrst_outputs got cv=%0b mv=%0b out=%0d rdy=%b a=%h d=%h err=%0b want all 0",
                     core_tvalid, m_tvalid, outstanding, s_tready, core_a, m_tdata, seq_err);
            errors++;
        end
        @(posedge clk);
        #1;
        s_tvalid = '0;
        rst = 1'b0;
        model_reset();
        stray_v = 1'b1;
        stray_d = $urandom;
        @(negedge clk);
        checks++; if (seq_err !== m_err) begin $display("FAIL midrst_err_pre got %0b want %0b", seq_err, m_err); errors++; end
        advance();
        stray_v = 1'b0;
        for (int c = 0; c < L + 3; c++) begin
            @(negedge clk);
            checks++;
            if (seq_err !== 1'b1 || m_tvalid !== 1'b0 || outstanding !== 4'd0) begin
                $display("FAIL midrst_stray[%0d] got err=%0b v=%0b out=%0d want 1/0/0", c, seq_err, m_tvalid, outstanding);
                errors++;
            end
            advance();
        end
    endtask

`ifdef IPSXE_FLT_ARB_PRIO0_EN
    task automatic test_prio0();
        m_tready = 1'b1;
        s_tvalid = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            rand_lanes();
            @(negedge clk);
            checks++;
            if (s_tready !== 4'b0001 || s_tready !== exp_ready()) begin
                $display("FAIL prio_grant0[%0d] got %b want 0001", c, s_tready); errors++;
            end
            advance();
        end
        s_tvalid = 4'b0100;
        @(negedge clk);
        checks++;
        if (s_tready !== 4'b0100) begin $display("FAIL prio_grant2 got %b want 0100", s_tready); errors++; end
        advance();
        drain_and_check("prio");
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_credit_stall();
        test_accept_and_pop();
        test_back_to_back_random();
        test_reset_midflight();
`ifdef IPSXE_FLT_ARB_PRIO0_EN
        test_prio0();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ipsxe_floating_point_op_arb_v1_0.md
Name: ipsxe_floating_point_op_arb_v1_0

Overview:
Round-robin arbiter and sequencer that shares one fixed-latency floating-point core (add/sub/compare) between N_REQ AXI4-Stream requesters. It registers the winning operand pair and 8-bit operation byte into the core and tags each issue with its requester ID in a latency-matched tag pipeline. Core results are buffered in a result FIFO with credit-based admission, so the non-stallable core can never overflow it. Results are returned on one AXI4-Stream master, with the requester ID in tuser.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width
CORE_LATENCY, 4, cycles from o_core_tvalid to i_core_rvalid (>=1)
FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2)
ID_W, 3, requester ID width (>= clog2(N_REQ))

Ports:
i_aclk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_s_tvalid  in  N_REQ  per-requester valid
o_s_tready  out  N_REQ  per-requester ready
i_s_a_tdata  in  N_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
i_s_b_tdata  in  N_REQ*DATA_W  operand B
i_s_op_tdata  in  N_REQ*8  operation byte (same encoding as core operation channel)
o_core_tvalid  out  1  issue strobe to core
o_core_a_tdata  out  DATA_W  issued operand A
o_core_b_tdata  out  DATA_W  issued operand B
o_core_op_tdata  out  8  issued operation byte
i_core_rvalid  in  1  core result valid
i_core_rdata  in  DATA_W  core result
o_m_tvalid  out  1  result valid
i_m_tready  in  1  result ready
o_m_tdata  out  DATA_W  result
o_m_tuser  out  ID_W  originating requester ID
o_seq_err  out  1  sticky sequence error
o_outstanding  out  clog2(FIFO_DEPTH)+1  in-flight plus buffered count

Behaviour:
- Reset (async assert, sync release to i_aclk): all outputs 0; RR pointer = 0; tag pipeline cleared; FIFO empty; outstanding = 0. Reset mid-operation discards in-flight and buffered results; later core results arriving without a tag set o_seq_err only once o_seq_err is out of reset and the tag pipeline holds a 0 bit.
- Admission: can_issue = (outstanding < FIFO_DEPTH).
- Arbitration: grant = first i with i_s_tvalid[i], searching from the RR pointer upward with wrap.
- o_s_tready[i] = can_issue & grant[i]. This is combinational from i_s_tvalid, and at most one bit is high.
- Accept: on o_s_tready[i] & i_s_tvalid[i], the RR pointer moves to (i+1) mod N_REQ. With no accept, the pointer holds.
- Issue: on accept at cycle t, o_core_tvalid=1 and operands/op are registered at t+1 for exactly one cycle. Data outputs hold their last value when o_core_tvalid=0.
- Tag pipeline: CORE_LATENCY+1 stages of {valid, ID}, advancing every cycle and loaded with the accepted ID at t+1. The tag output is aligned with i_core_rvalid at t+1+CORE_LATENCY.
- Result capture: on i_core_rvalid with tag valid, push {ID, i_core_rdata} into the FIFO.
- Mismatch (i_core_rvalid XOR tag valid): set o_seq_err (sticky until reset) and drop the beat; outstanding is not decremented by the capture path.
- Output: FIFO head drives o_m_tdata/o_m_tuser; o_m_tvalid = FIFO not empty. Data is registered, and first-word latency is one cycle after push (o_m_tvalid at t+2+CORE_LATENCY).
- Pop: a pop occurs on o_m_tvalid & i_m_tready. Data must stay stable while stalled.
- Outstanding counter: +1 on accept, -1 on pop, unchanged when both happen in the same cycle. It never exceeds FIFO_DEPTH, so a push to a full FIFO cannot occur by construction.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from an extra pointer MSB.
- Back-to-back: one issue per cycle is sustainable while i_m_tready=1 and outstanding < FIFO_DEPTH.

Optional Feature:
IPSXE_FLT_ARB_PRIO0_EN
- Defined: requester 0 has strict priority. Whenever i_s_tvalid[0]=1 and can_issue, requester 0 is granted. The remaining requesters are served round-robin among themselves, and the pointer advances only on non-0 grants.
- Not defined: pure round-robin as described in Behaviour.

Test Plan:
- Single request: req1 a=0x3F800000, b=0x40000000, op=0x00 at cycle 10 -> o_core_tvalid at 11 carrying those values; with core result 0x40400000 returned at 15, o_m_tvalid at 16 with tdata=0x40400000, tuser=1.
- Round-robin: all 4 tvalid held high -> accept order 0,1,2,3,0,1 on consecutive cycles; o_m_tuser sequence matches.
- Credit stall: i_m_tready=0 with all requesters active -> exactly 8 accepts, then o_s_tready=0 and o_outstanding=8; one pop -> exactly one further accept.
- Simultaneous accept and pop at outstanding=5 -> outstanding stays 5; FIFO order preserved.
- Reset mid-flight: assert i_rst with 3 in flight -> all outputs 0 immediately; after release, a stray i_core_rvalid -> o_seq_err=1 with no o_m_tvalid.
- With IPSXE_FLT_ARB_PRIO0_EN: req0 and req2 continuously valid -> req0 granted every cycle and req2 never granted until req0 drops tvalid.
